// File: rtl/channel_pkg.sv
// Shared types and constants for the encoder-to-decoder channel model.
package channel_pkg;

    localparam int unsigned LFSR_W = 16;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'd0,
        MODE_DELAY      = 2'd1,
        MODE_RANDOM_BIT = 2'd2,
        MODE_BURST      = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    // Right-shift Fibonacci form: polynomial taps 16,14,13,11 sit at register bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/channel_lfsr.sv
// 16-bit Fibonacci LFSR that advances only when enabled; reset loads SEED.
module channel_lfsr
    import channel_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/channel_model.sv
// Channel between encoder and decoder: bypass wire or delayed path with
// LFSR-driven single-bit / burst error injection and a corrupted-word counter.
module channel_model
    import channel_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DELAY     = 4,
    parameter int unsigned       BURST_LEN = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic [15:0]       err_thresh_i,
    input  logic              clr_cnt_i,
    input  logic              valid_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              valid_o,
    output logic [WIDTH-1:0]  data_o,
    output logic              err_flag_o,
    output logic [15:0]       err_cnt_o
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    mode_e             w_mode;
    logic [LFSR_W-1:0] w_lfsr;
    logic              w_lfsr_en;
    logic              w_hit;
    logic [WIDTH-1:0]  w_rep;
    logic [WIDTH-1:0]  w_mask;
    logic [WIDTH-1:0]  w_flip;
    logic              w_burst_hit;
    logic [WIDTH-1:0]  w_in_data;
    logic              w_in_flag;

    burst_state_e      r_state;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_line_v [DELAY];
    logic [WIDTH-1:0]  r_line_d [DELAY];
    logic              r_line_f [DELAY];
    logic [15:0]       r_err_cnt;

    assign w_mode    = mode_e'(mode_i);
    assign w_lfsr_en = valid_i && (w_mode != MODE_BYPASS);

    channel_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_lfsr_en),
        .o_lfsr (w_lfsr)
    );

    assign w_hit = (w_lfsr < err_thresh_i);

    // Burst mask: LFSR replicated across the word; an all-zero mask would hide the burst.
    for (genvar g = 0; g < WIDTH; g++) begin : g_rep
        assign w_rep[g] = w_lfsr[g % LFSR_W];
    end
    assign w_mask = (w_rep == '0) ? WIDTH'(1) : w_rep;
    assign w_flip = WIDTH'(1) << (32'(w_lfsr[7:0]) % WIDTH);

    // The trigger word itself is the first corrupted word of a burst.
    assign w_burst_hit = valid_i && ((r_state == ST_BURST) || w_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
        end else if (w_mode != MODE_BURST) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
        end else if (valid_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit && (BURST_LEN > 1)) begin
                        r_state     <= ST_BURST;
                        r_burst_cnt <= CNT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (r_burst_cnt == CNT_W'(BURST_LEN - 1)) begin
                        r_state     <= ST_IDLE;
                        r_burst_cnt <= '0;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_in_data = data_i;
        w_in_flag = 1'b0;
        case (w_mode)
            MODE_RANDOM_BIT: begin
                if (valid_i && w_hit) begin
                    w_in_data = data_i ^ w_flip;
                    w_in_flag = 1'b1;
                end
            end
            MODE_BURST: begin
                if (w_burst_hit) begin
                    w_in_data = data_i ^ w_mask;
                    w_in_flag = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Transport delay; bypass mode empties the line so nothing stale resurfaces later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                r_line_v[i] <= 1'b0;
                r_line_d[i] <= '0;
                r_line_f[i] <= 1'b0;
            end
        end else if (w_mode == MODE_BYPASS) begin
            for (int i = 0; i < DELAY; i++) begin
                r_line_v[i] <= 1'b0;
                r_line_d[i] <= '0;
                r_line_f[i] <= 1'b0;
            end
        end else begin
            r_line_v[0] <= valid_i;
            r_line_d[0] <= w_in_data;
            r_line_f[0] <= w_in_flag;
            for (int i = 1; i < DELAY; i++) begin
                r_line_v[i] <= r_line_v[i-1];
                r_line_d[i] <= r_line_d[i-1];
                r_line_f[i] <= r_line_f[i-1];
            end
        end
    end

    always_comb begin
        if (w_mode == MODE_BYPASS) begin
            valid_o    = valid_i;
            data_o     = data_i;
            err_flag_o = 1'b0;
        end else begin
            valid_o    = r_line_v[DELAY-1];
            data_o     = r_line_d[DELAY-1];
            err_flag_o = r_line_f[DELAY-1];
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_err_cnt <= '0;
        end else if (valid_o && err_flag_o && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_channel_model.sv
// Randomised bench for channel_model against a queue-based behavioural model.
module tb_channel_model;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DELAY     = 4;
    localparam int unsigned BURST_LEN = 3;
    localparam logic [15:0] SEED      = 16'hACE1;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             f;
    } word_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode_i = 2'd1;
    logic [15:0]      err_thresh_i = 16'h0;
    logic             clr_cnt_i = 1'b0;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             err_flag_o;
    logic [15:0]      err_cnt_o;

    int checks   = 0;
    int failures = 0;

    word_t       pipe[$];
    logic [15:0] m_lfsr;
    int          burst_left;
    logic [15:0] m_cnt;
    logic [1:0]  m_mode   = 2'd1;
    logic [15:0] m_thresh = 16'h0;
    logic        m_clr    = 1'b0;

    always #5 clk = ~clk;

    channel_model #(
        .WIDTH        (WIDTH),
        .DELAY        (DELAY),
        .BURST_LEN    (BURST_LEN),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode_i),
        .err_thresh_i (err_thresh_i),
        .clr_cnt_i    (clr_cnt_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .err_flag_o   (err_flag_o),
        .err_cnt_o    (err_cnt_o)
    );

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rep_mask(input logic [15:0] l);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) m[i] = l[i % 16];
        if (m == '0) m = 1;
        return m;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < DELAY; i++) pipe.push_back('0);
        m_lfsr     = SEED;
        burst_left = 0;
        m_cnt      = 16'h0;
    endtask

    // Drives one cycle of stimulus and returns what the outputs must show in that cycle.
    task automatic model_cycle(input logic v, input logic [WIDTH-1:0] d,
                               output word_t exp, output logic [15:0] exp_cnt);
        word_t w;
        @(negedge clk);
        mode_i       = m_mode;
        err_thresh_i = m_thresh;
        clr_cnt_i    = m_clr;
        valid_i      = v;
        data_i       = d;
        #1;
        exp_cnt = m_cnt;
        if (m_mode != 2'd3) burst_left = 0;
        if (m_mode == 2'd0) begin
            exp = '{v: v, d: d, f: 1'b0};
            foreach (pipe[i]) pipe[i] = '0;
        end else begin
            exp = pipe[DELAY-1];
            w = '{v: v, d: d, f: 1'b0};
            if (v && m_mode == 2'd2 && m_lfsr < m_thresh) begin
                w.d = d ^ (8'h01 << (int'(m_lfsr[7:0]) % WIDTH));
                w.f = 1'b1;
            end
            if (v && m_mode == 2'd3) begin
                if (burst_left == 0 && m_lfsr < m_thresh) burst_left = BURST_LEN;
                if (burst_left > 0) begin
                    w.d = d ^ rep_mask(m_lfsr);
                    w.f = 1'b1;
                    burst_left--;
                end
            end
            pipe.push_front(w);
            void'(pipe.pop_back());
            if (v) m_lfsr = ref_next(m_lfsr);
        end
        if (m_clr) m_cnt = 16'h0;
        else if (exp.v && exp.f && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic drain();
        word_t e;
        logic [15:0] ec;
        for (int i = 0; i < DELAY; i++) model_cycle(1'b0, '0, e, ec);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (valid_o !== 1'b0 || err_flag_o !== 1'b0 || err_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL reset_state got v=%b f=%b cnt=%h exp v=0 f=0 cnt=0000",
                     valid_o, err_flag_o, err_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_delay();
        word_t e;
        logic [15:0] ec;
        m_mode = 2'd1; m_thresh = 16'h0; m_clr = 1'b0;
        drain();
        for (int k = 0; k < 8; k++) begin
            model_cycle(k == 0, (k == 0) ? 8'hA5 : 8'($urandom), e, ec);
            checks++;
            if (valid_o !== (k == 4) || (k == 4 && (data_o !== 8'hA5 || err_flag_o !== 1'b0))) begin
                failures++;
                $display("FAIL delay_latency cyc=%0d got v=%b d=%h f=%b exp v=%b d=a5 f=0",
                         k, valid_o, data_o, err_flag_o, (k == 4));
            end
        end
    endtask

    task automatic test_bypass();
        word_t e;
        logic [15:0] ec;
        logic v;
        logic [WIDTH-1:0] d;
        m_mode = 2'd0;
        for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? 1'b1 : 1'($urandom);
            d = (k == 0) ? 8'h3C : 8'($urandom);
            model_cycle(v, d, e, ec);
            checks++;
            if (valid_o !== v || data_o !== d || err_flag_o !== 1'b0) begin
                failures++;
                $display("FAIL bypass cyc=%0d got v=%b d=%h f=%b exp v=%b d=%h f=0",
                         k, valid_o, data_o, err_flag_o, v, d);
            end
        end
    endtask

    task automatic test_mode_change();
        word_t e;
        logic [15:0] ec;
        m_mode = 2'd1;
        drain();
        for (int k = 0; k < 3; k++) model_cycle(1'b1, 8'($urandom), e, ec);
        m_mode = 2'd0;
        for (int k = 0; k < 2; k++) model_cycle(1'b0, 8'($urandom), e, ec);
        m_mode = 2'd1;
        for (int k = 0; k < DELAY + 1; k++) begin
            model_cycle(1'b0, 8'($urandom), e, ec);
            checks++;
            if (valid_o !== 1'b0 || valid_o !== e.v) begin
                failures++;
                $display("FAIL bypass_drops_line cyc=%0d got v=%b exp v=0", k, valid_o);
            end
        end
    endtask

    task automatic test_random_bit();
        word_t e;
        logic [15:0] ec;
        logic v;
        logic [WIDTH-1:0] d, o;
        logic [WIDTH-1:0] orig[$];
        int ones;
        m_mode = 2'd2; m_thresh = 16'h0; m_clr = 1'b1;
        model_cycle(1'b0, '0, e, ec);
        m_clr = 1'b0;
        drain();
        for (int k = 0; k < 1000 + DELAY; k++) begin
            v = (k < 1000) && ($urandom_range(0, 3) != 0);
            model_cycle(v, 8'($urandom), e, ec);
            checks++;
            if (valid_o !== e.v || (e.v && (data_o !== e.d || err_flag_o !== e.f))) begin
                failures++;
                $display("FAIL rbit_thresh0 cyc=%0d got v=%b d=%h f=%b exp v=%b d=%h f=%b",
                         k, valid_o, data_o, err_flag_o, e.v, e.d, e.f);
            end
        end
        checks++;
        if (err_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL rbit_thresh0_cnt got %h exp 0000", err_cnt_o);
        end
        m_thresh = 16'hFFFF;
        for (int k = 0; k < 1000 + DELAY; k++) begin
            v = (k < 1000) && ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (v) orig.push_back(d);
            model_cycle(v, d, e, ec);
            checks++;
            if (valid_o !== e.v || (e.v && (data_o !== e.d || err_flag_o !== e.f))) begin
                failures++;
                $display("FAIL rbit_full cyc=%0d got v=%b d=%h f=%b exp v=%b d=%h f=%b",
                         k, valid_o, data_o, err_flag_o, e.v, e.d, e.f);
            end
            if (e.v && orig.size() > 0) begin
                o = orig.pop_front();
                ones = $countones(data_o ^ o);
                checks++;
                if (ones != (e.f ? 1 : 0)) begin
                    failures++;
                    $display("FAIL rbit_one_bit cyc=%0d got %0d flipped bits exp %0d", k, ones, e.f ? 1 : 0);
                end
            end
        end
        checks++;
        if (err_cnt_o !== ec) begin
            failures++;
            $display("FAIL rbit_full_cnt got %h exp %h", err_cnt_o, ec);
        end
    endtask

    task automatic test_burst();
        word_t e;
        logic [15:0] ec;
        logic [9:0] pat;
        logic v;
        logic [WIDTH-1:0] d, o, m;
        logic [WIDTH-1:0] orig[$];
        logic [WIDTH-1:0] masks[$];
        int nvalid, nflag, nout;
        pat = 10'b1110100101;
        nvalid = 0; nflag = 0; nout = 0;
        m_mode = 2'd3; m_thresh = 16'h0;
        drain();
        for (int k = 0; k < 10 + DELAY; k++) begin
            v = (k < 10) ? pat[k] : 1'b0;
            d = 8'($urandom);
            m_thresh = (k == 0) ? ((m_lfsr == 16'hFFFF) ? 16'hFFFF : m_lfsr + 16'd1) : 16'h0;
            if (v) begin
                orig.push_back(d);
                masks.push_back((nvalid < BURST_LEN) ? rep_mask(m_lfsr) : '0);
                nvalid++;
            end
            model_cycle(v, d, e, ec);
            checks++;
            if (valid_o !== e.v || (e.v && (data_o !== e.d || err_flag_o !== e.f))) begin
                failures++;
                $display("FAIL burst_model cyc=%0d got v=%b d=%h f=%b exp v=%b d=%h f=%b",
                         k, valid_o, data_o, err_flag_o, e.v, e.d, e.f);
            end
            if (e.v) begin
                o = orig.pop_front();
                m = masks.pop_front();
                checks++;
                if ((data_o ^ o) !== m || err_flag_o !== (m != '0)) begin
                    failures++;
                    $display("FAIL burst_mask word=%0d got xor=%h f=%b exp xor=%h f=%b",
                             nout, data_o ^ o, err_flag_o, m, (m != '0));
                end
                if (err_flag_o === 1'b1) nflag++;
                nout++;
            end
        end
        checks++;
        if (nflag != BURST_LEN) begin
            failures++;
            $display("FAIL burst_len got %0d flagged exp %0d", nflag, BURST_LEN);
        end
    endtask

    task automatic test_reset_midstream();
        word_t e;
        logic [15:0] ec;
        logic [WIDTH-1:0] sd [16];
        logic sv [16];
        for (int i = 0; i < 16; i++) begin
            sd[i] = 8'($urandom);
            sv[i] = ($urandom_range(0, 3) != 0);
        end
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            m_mode = 2'd2; m_thresh = 16'h8000; m_clr = 1'b0;
            for (int k = 0; k < 16 + DELAY; k++) begin
                model_cycle((k < 16) ? sv[k] : 1'b0, (k < 16) ? sd[k] : '0, e, ec);
                checks++;
                if (valid_o !== e.v || (e.v && (data_o !== e.d || err_flag_o !== e.f)) || err_cnt_o !== ec) begin
                    failures++;
                    $display("FAIL reseed_pass%0d cyc=%0d got v=%b d=%h f=%b c=%h exp v=%b d=%h f=%b c=%h",
                             pass, k, valid_o, data_o, err_flag_o, err_cnt_o, e.v, e.d, e.f, ec);
                end
            end
            if (pass == 0) begin
                for (int k = 0; k < 4; k++) model_cycle(1'b1, 8'($urandom), e, ec);
                @(negedge clk);
                valid_i = 1'b0;
                rst_n   = 1'b0;
                #1;
                checks++;
                if (valid_o !== 1'b0 || err_cnt_o !== 16'h0) begin
                    failures++;
                    $display("FAIL reset_inflight got v=%b cnt=%h exp v=0 cnt=0000", valid_o, err_cnt_o);
                end
            end
        end
    endtask

    task automatic test_random_all();
        word_t e;
        logic [15:0] ec;
        for (int k = 0; k < 1500; k++) begin
            if (k % 25 == 0) begin
                m_mode = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0: m_thresh = 16'h0000;
                    1: m_thresh = 16'h0800;
                    2: m_thresh = 16'h4000;
                    3: m_thresh = 16'hC000;
                    default: m_thresh = 16'hFFFF;
                endcase
            end
            m_clr = ($urandom_range(0, 63) == 0);
            model_cycle($urandom_range(0, 9) < 7, 8'($urandom), e, ec);
            checks++;
            if (valid_o !== e.v || (e.v && (data_o !== e.d || err_flag_o !== e.f)) || err_cnt_o !== ec) begin
                failures++;
                $display("FAIL random_mix cyc=%0d mode=%0d got v=%b d=%h f=%b c=%h exp v=%b d=%h f=%b c=%h",
                         k, m_mode, valid_o, data_o, err_flag_o, err_cnt_o, e.v, e.d, e.f, ec);
            end
        end
        m_clr = 1'b0;
    endtask

    task automatic test_counter();
        word_t e;
        logic [15:0] ec;
        m_mode = 2'd2; m_thresh = 16'hFFFF; m_clr = 1'b0;
        drain();
        for (int k = 0; k < 8; k++) begin
            m_clr = (k == 5);
            model_cycle(1'b1, 8'($urandom), e, ec);
            if (k == 5) begin
                checks++;
                if (valid_o !== e.v || err_flag_o !== e.f) begin
                    failures++;
                    $display("FAIL clr_same_cycle_out got v=%b f=%b exp v=%b f=%b", valid_o, err_flag_o, e.v, e.f);
                end
            end
            if (k == 6) begin
                checks++;
                if (err_cnt_o !== 16'h0) begin
                    failures++;
                    $display("FAIL clr_wins got %h exp 0000", err_cnt_o);
                end
            end
        end
        m_clr = 1'b0;
        for (int k = 0; k < 65600; k++) model_cycle(1'b1, 8'($urandom), e, ec);
        checks++;
        if (err_cnt_o !== 16'hFFFF || err_cnt_o !== ec) begin
            failures++;
            $display("FAIL cnt_saturate got %h exp ffff (model %h)", err_cnt_o, ec);
        end
        for (int k = 0; k < 20; k++) model_cycle(1'b1, 8'($urandom), e, ec);
        checks++;
        if (err_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_hold got %h exp ffff", err_cnt_o);
        end
        m_clr = 1'b1;
        model_cycle(1'b1, 8'($urandom), e, ec);
        m_clr = 1'b0;
        model_cycle(1'b0, '0, e, ec);
        checks++;
        if (err_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL cnt_clear got %h exp 0000", err_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_delay();
        test_bypass();
        test_mode_change();
        test_random_bit();
        test_burst();
        test_reset_midstream();
        test_random_all();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
